// File: rtl/multicycle_controller.sv
// Multicycle instruction-sequencing controller for a small RISC-V style datapath.
// A six-state FSM steps each instruction through fetch, decode, execute, memory and writeback.
module multicycle_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic        mem_to_reg,
    output logic        instr_done,
    output logic        trap,
    output logic [2:0]  state,
    output logic [15:0] retired_count
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd5
    } state_e;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    state_e      state_q, state_d;
    logic [6:0]  op_q, op_d;
    logic [2:0]  f3_q, f3_d;
    logic [15:0] count_q, count_d;
    logic        br_taken;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
            op_q    <= 7'd0;
            f3_q    <= 3'd0;
            count_q <= 16'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            f3_q    <= f3_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        f3_d    = f3_q;
        count_d = count_q + {15'd0, instr_done};
        case (state_q)
            StFetch: begin
                if (mem_ready) state_d = StDecode;
            end
            StDecode: begin
                op_d = opcode;
                f3_d = funct3;
                if (opcode inside {OpR, OpI, OpLoad, OpStore, OpBranch}) state_d = StExec;
                else state_d = StTrap;
            end
            StExec: begin
                case (op_q)
                    OpR, OpI:         state_d = StWb;
                    OpLoad, OpStore:  state_d = StMem;
                    default:          state_d = StFetch;
                endcase
            end
            StMem: begin
                if (mem_ready) state_d = (op_q == OpLoad) ? StWb : StFetch;
            end
            StWb:    state_d = StFetch;
            StTrap:  state_d = StTrap;
            // Unused encodings 6 and 7 recover to fetch.
            default: state_d = StFetch;
        endcase
    end

    assign br_taken = ((f3_q == 3'b000) && zero) || ((f3_q == 3'b001) && !zero);

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 2'b00;
        mem_to_reg = 1'b0;
        instr_done = 1'b0;
        trap       = 1'b0;
        case (state_q)
            StFetch: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            StExec: begin
                case (op_q)
                    OpR: alu_op = 2'b10;
                    OpI: begin
                        alu_src = 1'b1;
                        alu_op  = 2'b10;
                    end
                    OpLoad, OpStore: alu_src = 1'b1;
                    OpBranch: begin
                        alu_op     = 2'b01;
                        pc_write   = br_taken;
                        instr_done = 1'b1;
                    end
                    default: ;
                endcase
            end
            StMem: begin
                if (op_q == OpLoad) begin
                    mem_read = 1'b1;
                end else begin
                    mem_write  = 1'b1;
                    instr_done = mem_ready;
                end
            end
            StWb: begin
                reg_write  = 1'b1;
                mem_to_reg = (op_q == OpLoad);
                instr_done = 1'b1;
            end
            StTrap:  trap = 1'b1;
            default: ;
        endcase
    end

    assign state         = state_q;
    assign retired_count = count_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction expectations are queued by the driver
// and consumed by a monitor on every instr_done pulse.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  opcode = 7'd0;
    logic [2:0]  funct3 = 3'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_write, ir_write, mem_read, mem_write, reg_write, alu_src;
    logic [1:0]  alu_op;
    logic        mem_to_reg, instr_done, trap;
    logic [2:0]  state;
    logic [15:0] retired_count;

    multicycle_controller dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .funct3        (funct3),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .ir_write      (ir_write),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .reg_write     (reg_write),
        .alu_src       (alu_src),
        .alu_op        (alu_op),
        .mem_to_reg    (mem_to_reg),
        .instr_done    (instr_done),
        .trap          (trap),
        .state         (state),
        .retired_count (retired_count)
    );

    always #5 clk = ~clk;

    localparam int KR = 0, KI = 1, KLD = 2, KST = 3, KBR = 4;

    typedef struct {
        int cycles;
        int path;
        int n_mr;
        int n_mw;
        int n_pc;
        int n_ir;
        int n_rw;
        int n_m2r;
        int exec_sig;
        int retired;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] exp_count = 16'd0;
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic logic [6:0] op_of(input int k);
        case (k)
            KR:      return 7'b0110011;
            KI:      return 7'b0010011;
            KLD:     return 7'b0000011;
            KST:     return 7'b0100011;
            default: return 7'b1100011;
        endcase
    endfunction

    // Sequence of distinct states an instruction walks through, packed 3 bits per state.
    function automatic int path_of(input int k);
        int q[$];
        int p;
        q = {0, 1, 2};
        if (k == KLD || k == KST) q.push_back(3);
        if (k == KR || k == KI || k == KLD) q.push_back(4);
        p = 0;
        foreach (q[i]) p = p * 8 + q[i];
        return p;
    endfunction

    function automatic int exec_sig_of(input int k);
        case (k)
            KR:       return 3'b010;
            KI:       return 3'b110;
            KLD, KST: return 3'b100;
            default:  return 3'b001;
        endcase
    endfunction

    // fw / mw: cycles of mem_ready=0 before the handshake in FETCH / MEM.
    task automatic run_instr(input int k, input int fw, input int mw,
                             input logic [2:0] f3, input logic zx);
        exp_t e;
        int   n;
        bit   is_mem;
        bit   taken;
        logic mr_plan[32];
        logic z_plan[32];
        is_mem = (k == KLD || k == KST);
        n = ((k == KBR) ? 3 : (k == KLD) ? 5 : 4) + fw + (is_mem ? mw : 0);
        for (int i = 0; i < n; i++) begin
            mr_plan[i] = 1'($urandom_range(0, 1));
            z_plan[i]  = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i <= fw; i++) mr_plan[i] = (i == fw);
        if (is_mem) for (int i = 0; i <= mw; i++) mr_plan[fw + 3 + i] = (i == mw);
        z_plan[fw + 2] = zx;
        taken = (k == KBR) && ((f3 == 3'b000 && zx) || (f3 == 3'b001 && !zx));
        e.cycles   = n;
        e.path     = path_of(k);
        e.n_mr     = fw + 1 + ((k == KLD) ? mw + 1 : 0);
        e.n_mw     = (k == KST) ? mw + 1 : 0;
        e.n_pc     = 1 + int'(taken);
        e.n_ir     = 1;
        e.n_rw     = (k == KR || k == KI || k == KLD) ? 1 : 0;
        e.n_m2r    = (k == KLD) ? 1 : 0;
        e.exec_sig = exec_sig_of(k);
        e.retired  = int'(exp_count);
        sb.push_back(e);
        exp_count++;
        for (int i = 0; i < n; i++) begin
            opcode    = (i <= fw + 1) ? op_of(k) : 7'($urandom);
            funct3    = (i <= fw + 1) ? f3 : 3'($urandom);
            zero      = z_plan[i];
            mem_ready = mr_plan[i];
            @(posedge clk);
            #1;
        end
        check("retired_after", int'(retired_count), int'(exp_count));
    endtask

    task automatic reset_dut();
        reset     = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        exp_count = 16'd0;
    endtask

    // Monitor: accumulate per-instruction activity, compare on each instr_done.
    int       m_cyc, m_path, m_mr, m_mw, m_pc, m_ir, m_rw, m_m2r, m_both, m_exec;
    logic [2:0] m_last;
    exp_t     m_e;

    task automatic mon_clear();
        m_cyc = 0; m_path = 0; m_mr = 0; m_mw = 0; m_pc = 0; m_ir = 0;
        m_rw = 0; m_m2r = 0; m_both = 0; m_exec = -1; m_last = 3'd7;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            mon_clear();
        end else begin
            m_cyc++;
            if (state != m_last) begin
                m_path = m_path * 8 + int'(state);
                m_last = state;
            end
            m_mr   += int'(mem_read);
            m_mw   += int'(mem_write);
            m_pc   += int'(pc_write);
            m_ir   += int'(ir_write);
            m_rw   += int'(reg_write);
            m_m2r  += int'(reg_write && mem_to_reg);
            m_both += int'(mem_read && mem_write);
            if (state == 3'd2) m_exec = int'({alu_src, alu_op});
            if (instr_done) begin
                if (sb.size() == 0) begin
                    check("unexpected_instr_done", 1, 0);
                end else begin
                    m_e = sb.pop_front();
                    check("cycles", m_cyc, m_e.cycles);
                    check("state_path", m_path, m_e.path);
                    check("mem_read_cycles", m_mr, m_e.n_mr);
                    check("mem_write_cycles", m_mw, m_e.n_mw);
                    check("pc_write_cycles", m_pc, m_e.n_pc);
                    check("ir_write_cycles", m_ir, m_e.n_ir);
                    check("reg_write_cycles", m_rw, m_e.n_rw);
                    check("mem_to_reg_wb", m_m2r, m_e.n_m2r);
                    check("rd_wr_overlap", m_both, 0);
                    check("exec_alu_ctrl", m_exec, m_e.exec_sig);
                    check("retired_at_done", int'(retired_count), m_e.retired);
                end
                mon_clear();
            end
        end
    end

    int bad;

    initial begin
        mon_clear();
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_state", int'(state), 0);
        check("reset_trap", int'(trap), 0);
        check("reset_count", int'(retired_count), 0);
        check("reset_fetch_read", int'(mem_read), 1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // STORE abandoned by reset while its memory request is pending.
        opcode = 7'b0100011; funct3 = 3'b010; zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("abort_mem_write_pending", int'(mem_write), 1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_state", int'(state), 0);
        check("abort_no_mem_write", int'(mem_write), 0);
        check("abort_mem_read", int'(mem_read), 1);
        check("abort_count", int'(retired_count), 0);
        reset_dut();

        run_instr(KR, 0, 0, 3'b000, 1'b0);
        run_instr(KLD, 0, 2, 3'b010, 1'b0);
        run_instr(KBR, 0, 0, 3'b000, 1'b1);
        run_instr(KBR, 0, 0, 3'b001, 1'b1);

        for (int i = 0; i < 300; i++) begin
            run_instr($urandom_range(0, 4), $urandom_range(0, 2), $urandom_range(0, 2),
                      3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end

        // Counter wrap: 65535 short instructions, then one more.
        reset_dut();
        for (int i = 0; i < 65535; i++) begin
            run_instr(KBR, 0, 0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end
        check("count_at_ffff", int'(retired_count), 16'hFFFF);
        run_instr(KR, 0, 0, 3'b000, 1'b0);

        // Illegal opcode traps and stays trapped until reset.
        opcode = 7'b1111111; mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            zero      = 1'($urandom_range(0, 1));
            opcode    = 7'($urandom);
            @(negedge clk);
            if (state != 3'd5 || !trap || pc_write || ir_write || mem_read || mem_write ||
                reg_write || alu_src || alu_op != 2'b00 || mem_to_reg || instr_done) bad++;
            @(posedge clk); #1;
        end
        check("trap_hold_bad_cycles", bad, 0);
        check("trap_count", int'(retired_count), int'(exp_count));
        reset_dut();
        @(negedge clk);
        check("post_trap_state", int'(state), 0);
        check("post_trap_flag", int'(trap), 0);
        check("post_trap_read", int'(mem_read), 1);
        check("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
